p2s_symbol_ctrl: RTL and testbench

// - Sequencer for the OFDM parallel-to-serial shifter. Accepts one IFFT symbol at a time via valid/ready.
// - Drives the shifter's load/en controls.
// - Presents the serial stream downstream with valid/ready back-pressure, SOF/EOF flags and a completed-symbol count.
// - Sits between the IFFT output buffer and the serial baseband stage.

---
 rtl/p2s_symbol_ctrl_if.sv | 29 ++
 rtl/p2s_symbol_ctrl.sv | 103 ++++++++++
 tb/tb_p2s_symbol_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p2s_symbol_ctrl_if.sv
// Handshake bundle shared by the P2S symbol sequencer, its IFFT symbol source,
// the shifter controls and the serial downstream sink.
interface p2s_symbol_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = 16
);
  logic             flush;
  logic             sym_valid;
  logic             sym_ready;
  logic             p2s_load;
  logic             p2s_en;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_eof;
  logic [IDX_W-1:0] sample_idx;
  logic [CNT_W-1:0] sym_count;

  modport master (
    output flush, sym_valid, out_ready,
    input  sym_ready, p2s_load, p2s_en, out_valid, out_sof, out_eof, sample_idx, sym_count
  );

  modport slave (
    input  flush, sym_valid, out_ready,
    output sym_ready, p2s_load, p2s_en, out_valid, out_sof, out_eof, sample_idx, sym_count
  );
endinterface

// File: rtl/p2s_symbol_ctrl.sv
// Sequencer for the OFDM parallel-to-serial shifter: accepts one IFFT symbol at a time and
// streams it downstream with back-pressure. Optional guard gap between symbols: GUARD_GAP_EN.
module p2s_symbol_ctrl #(
  parameter int DEPTH   = 8,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int CNT_W   = 16,
  parameter int GAP_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  p2s_symbol_ctrl_if.slave bus
);

`ifdef GUARD_GAP_EN
  localparam bit GAP_EN  = 1'b1;
  localparam int GAP_CYC = GAP_LEN;
`else
  localparam bit GAP_EN  = 1'b0;
  localparam int GAP_CYC = 0;
`endif
  localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] sym_count;
  logic             last;
  logic             accept;
  logic             beat;

  assign last   = (idx == IDX_LAST);
  // Back-to-back accept on the final beat only when no guard gap is built in.
  assign bus.sym_ready = !bus.flush &&
                         ((state == IDLE) ||
                          ((state == SHIFT) && last && bus.out_ready && !GAP_EN));
  assign accept = bus.sym_valid && bus.sym_ready;
  assign beat   = bus.out_valid && bus.out_ready;

  assign bus.p2s_load   = accept;
  assign bus.p2s_en     = accept || ((state == SHIFT) && bus.out_ready);
  assign bus.out_valid  = (state == SHIFT);
  assign bus.out_sof    = (state == SHIFT) && (idx == '0);
  assign bus.out_eof    = (state == SHIFT) && last;
  assign bus.sample_idx = idx;
  assign bus.sym_count  = sym_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      gap_cnt   <= '0;
      sym_count <= '0;
    end else if (bus.flush) begin
      state   <= IDLE;
      idx     <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SHIFT;
            idx   <= '0;
          end
        end
        SHIFT: begin
          if (beat) begin
            if (!last) begin
              idx <= idx + IDX_W'(1);
            end else begin
              sym_count <= sym_count + CNT_W'(1);
              idx       <= '0;
              if (accept) begin
                state <= SHIFT;
              end else if (GAP_CYC > 0) begin
                state   <= GAP;
                gap_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        GAP: begin
          if (int'(gap_cnt) >= GAP_CYC - 1) begin
            state   <= IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_symbol_ctrl.sv
// Self-checking bench for p2s_symbol_ctrl: transaction-level model of the symbol stream
// plus a behavioural shifter driven by the DUT's load/en controls.
module tb_p2s_symbol_ctrl;
  localparam int DEPTH   = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 16;
  localparam int GAP_LEN = 4;
`ifdef GUARD_GAP_EN
  localparam bit GAP_EN  = 1'b1;
  localparam int GAP_CYC = GAP_LEN;
`else
  localparam bit GAP_EN  = 1'b0;
  localparam int GAP_CYC = 0;
`endif
  localparam int VW = 6 + IDX_W + CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  p2s_symbol_ctrl_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) sif ();

  p2s_symbol_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W), .GAP_LEN(GAP_LEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  // Shifter stand-in: parallel load, serial output at sh[0]
  logic [7:0] sym_data [DEPTH];
  logic [7:0] sh [DEPTH];
  always @(posedge clk) begin
    if (sif.p2s_load) begin
      for (int i = 0; i < DEPTH; i++) sh[i] <= sym_data[i];
    end else if (sif.p2s_en) begin
      for (int i = 0; i < DEPTH - 1; i++) sh[i] <= sh[i+1];
      sh[DEPTH-1] <= 8'h00;
    end
  end

  // Stream model: active symbol, position in it, guard cycles left, completed count
  bit               m_act = 1'b0;
  int               m_pos = 0;
  int               m_gap = 0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic [7:0]       m_sym [DEPTH];
  bit               c_v, c_r, c_f, new_sym;
  logic             e_ready, e_load, e_en, e_valid, e_sof, e_eof;
  logic [IDX_W-1:0] e_idx;
  int               errors = 0;
  int               checks = 0;

  function automatic logic [VW-1:0] exp_vec();
    return {e_ready, e_load, e_en, e_valid, e_sof, e_eof, e_valid ? e_idx : IDX_W'(0), m_cnt};
  endfunction

  function automatic logic [VW-1:0] got_vec();
    return {sif.sym_ready, sif.p2s_load, sif.p2s_en, sif.out_valid, sif.out_sof, sif.out_eof,
            sif.out_valid ? sif.sample_idx : IDX_W'(0), sif.sym_count};
  endfunction

  task automatic model_reset();
    m_act = 1'b0; m_pos = 0; m_gap = 0; m_cnt = '0;
  endtask

  task automatic predict();
    e_valid = m_act;
    e_idx   = IDX_W'(m_pos);
    e_sof   = m_act && (m_pos == 0);
    e_eof   = m_act && (m_pos == DEPTH - 1);
    e_ready = !c_f && ((!m_act && m_gap == 0) ||
                       (m_act && m_pos == DEPTH - 1 && c_r && !GAP_EN));
    e_load  = c_v && e_ready;
    e_en    = e_load || (m_act && c_r);
  endtask

  task automatic commit();
    new_sym = 1'b0;
    if (e_load) begin
      for (int i = 0; i < DEPTH; i++) m_sym[i] = sym_data[i];
      new_sym = 1'b1;
    end
    if (rst) begin
      model_reset();
    end else if (c_f) begin
      m_act = 1'b0; m_pos = 0; m_gap = 0;
    end else if (m_act) begin
      if (c_r) begin
        if (m_pos < DEPTH - 1) begin
          m_pos++;
        end else begin
          m_cnt = m_cnt + CNT_W'(1);
          if (e_load) m_pos = 0;
          else begin m_act = 1'b0; m_pos = 0; m_gap = GAP_CYC; end
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (e_load) begin
      m_act = 1'b1; m_pos = 0;
    end
  endtask

  task automatic tick_pre(input bit v, input bit r, input bit f);
    c_v = v; c_r = r; c_f = f;
    sif.sym_valid = v; sif.out_ready = r; sif.flush = f;
    predict();
    @(negedge clk);
  endtask

  task automatic tick_post();
    @(posedge clk);
    commit();
    #1;
    if (new_sym) for (int i = 0; i < DEPTH; i++) sym_data[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    tick_pre(1'b0, 1'b1, 1'b0);
    checks++;
    if (got_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", got_vec(), exp_vec());
    end
    tick_post();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick_pre(c == 0, 1'b1, 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_pre c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
      tick_post();
    end
    sif.sym_valid = 1'b0; c_v = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (sif.out_valid !== 1'b0 || sif.sym_ready !== 1'b1 || sif.sym_count !== 16'd0) begin
      errors++; $display("FAIL reset_mid valid=%b ready=%b count=%0d want 0/1/0",
                         sif.out_valid, sif.sym_ready, sif.sym_count);
    end
    model_reset();
    tick_pre(1'b0, 1'b1, 1'b0);
    tick_post();
    rst = 1'b0;
    for (int c = 0; c < 10 + GAP_CYC; c++) begin
      tick_pre(c == 0, 1'b1, 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_after c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
      if (e_valid && c_r) begin
        checks++;
        if (sh[0] !== m_sym[m_pos]) begin
          errors++; $display("FAIL reset_data pos=%0d got=%0d exp=%0d", m_pos, sh[0], m_sym[m_pos]);
        end
      end
      tick_post();
    end
  endtask

  task automatic test_single_symbol();
    int loads = 0, beats = 0;
    logic [7:0] sof_d = 8'h00, eof_d = 8'h00;
    logic [CNT_W-1:0] cnt0 = m_cnt;
    for (int i = 0; i < DEPTH; i++) sym_data[i] = 8'(60 + 10 * i);
    for (int c = 0; c < 14; c++) begin
      tick_pre(c == 0, 1'b1, 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL single c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
      if (sif.p2s_load) loads++;
      if (sif.out_valid && sif.out_ready) beats++;
      if (sif.out_valid && sif.out_sof) sof_d = sh[0];
      if (sif.out_valid && sif.out_eof) eof_d = sh[0];
      tick_post();
    end
    checks++;
    if (loads !== 1 || beats !== DEPTH) begin
      errors++; $display("FAIL single_counts loads=%0d beats=%0d want 1/8", loads, beats);
    end
    checks++;
    if (sof_d !== 8'd60 || eof_d !== 8'd130) begin
      errors++; $display("FAIL single_flags sof=%0d eof=%0d want 60/130", sof_d, eof_d);
    end
    checks++;
    if (sif.sym_count !== cnt0 + CNT_W'(1) || sif.sym_ready !== 1'b1 || sif.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_end count=%0d ready=%b valid=%b want %0d/1/0",
                         sif.sym_count, sif.sym_ready, sif.out_valid, cnt0 + CNT_W'(1));
    end
  endtask

  task automatic test_backpressure();
    int beats = 0;
    for (int c = 0; c < 21; c++) begin
      tick_pre(c == 0, !(c >= 5 && c <= 7), 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL bp c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
      if (c >= 5 && c <= 7) begin
        checks++;
        if (sif.p2s_en !== 1'b0 || sif.sample_idx !== 3'd4) begin
          errors++; $display("FAIL bp_hold c=%0d en=%b idx=%0d want 0/4", c, sif.p2s_en, sif.sample_idx);
        end
      end
      if (e_valid && c_r) begin
        beats++;
        checks++;
        if (sh[0] !== m_sym[m_pos]) begin
          errors++; $display("FAIL bp_data pos=%0d got=%0d exp=%0d", m_pos, sh[0], m_sym[m_pos]);
        end
      end
      tick_post();
    end
    checks++;
    if (beats !== DEPTH) begin
      errors++; $display("FAIL bp_beats got=%0d want 8", beats);
    end
  endtask

  task automatic test_back_to_back();
    int nload = 0, dload = 0, beats = 0, run = 0, maxrun = 0, idle = 0;
    int eof_cyc = -1, load2_cyc = -1;
    logic [CNT_W-1:0] cnt0 = m_cnt;
    for (int c = 0; c < 32; c++) begin
      tick_pre(nload < 2, 1'b1, 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
      if (e_valid && c_r) begin
        checks++;
        if (sh[0] !== m_sym[m_pos]) begin
          errors++; $display("FAIL b2b_data pos=%0d got=%0d exp=%0d", m_pos, sh[0], m_sym[m_pos]);
        end
      end
      if (eof_cyc >= 0 && dload < 2 && !sif.out_valid && !sif.sym_ready) idle++;
      if (sif.p2s_load) begin dload++; if (dload == 2) load2_cyc = c; end
      if (sif.out_valid && sif.out_ready) begin
        beats++;
        if (sif.out_eof && eof_cyc < 0) eof_cyc = c;
      end
      run = sif.out_valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (e_load) nload++;
      tick_post();
    end
    checks++;
    if (beats !== 2 * DEPTH || maxrun !== (GAP_EN ? DEPTH : 2 * DEPTH)) begin
      errors++; $display("FAIL b2b_beats beats=%0d run=%0d want 16/%0d", beats, maxrun,
                         GAP_EN ? DEPTH : 2 * DEPTH);
    end
    checks++;
    if (eof_cyc < 0 || load2_cyc !== (GAP_EN ? eof_cyc + GAP_CYC + 1 : eof_cyc)) begin
      errors++; $display("FAIL b2b_load2 eof=%0d load2=%0d", eof_cyc, load2_cyc);
    end
    checks++;
    if (idle !== GAP_CYC) begin
      errors++; $display("FAIL b2b_gap idle=%0d want %0d", idle, GAP_CYC);
    end
    checks++;
    if (sif.sym_count !== cnt0 + CNT_W'(2)) begin
      errors++; $display("FAIL b2b_count got=%0d want %0d", sif.sym_count, cnt0 + CNT_W'(2));
    end
  endtask

  task automatic test_flush();
    logic [CNT_W-1:0] cnt0 = m_cnt;
    for (int c = 0; c < 24; c++) begin
      tick_pre(c == 0 || c == 6 || c == 7, 1'b1, c == 6);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL flush c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
      if (c == 6) begin
        checks++;
        if (sif.sample_idx !== 3'd5 || sif.sym_ready !== 1'b0 || sif.p2s_load !== 1'b0) begin
          errors++; $display("FAIL flush_cycle idx=%0d ready=%b load=%b want 5/0/0",
                             sif.sample_idx, sif.sym_ready, sif.p2s_load);
        end
      end
      if (c == 7) begin
        checks++;
        if (sif.out_valid !== 1'b0 || sif.sym_ready !== 1'b1 || sif.sym_count !== cnt0) begin
          errors++; $display("FAIL flush_idle valid=%b ready=%b count=%0d want 0/1/%0d",
                             sif.out_valid, sif.sym_ready, sif.sym_count, cnt0);
        end
      end
      if (c == 8) begin
        checks++;
        if (sif.out_sof !== 1'b1 || sif.sample_idx !== 3'd0) begin
          errors++; $display("FAIL flush_restart sof=%b idx=%0d want 1/0", sif.out_sof, sif.sample_idx);
        end
      end
      if (e_valid && c_r) begin
        checks++;
        if (sh[0] !== m_sym[m_pos]) begin
          errors++; $display("FAIL flush_data pos=%0d got=%0d exp=%0d", m_pos, sh[0], m_sym[m_pos]);
        end
      end
      tick_post();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      tick_pre(1'($urandom_range(0, 1)), ($urandom % 4) != 0, ($urandom % 60) == 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL random c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
      if (e_valid && c_r) begin
        checks++;
        if (sh[0] !== m_sym[m_pos]) begin
          errors++; $display("FAIL random_data pos=%0d got=%0d exp=%0d", m_pos, sh[0], m_sym[m_pos]);
        end
      end
      tick_post();
    end
  endtask

  initial begin
    sif.sym_valid = 1'b0;
    sif.out_ready = 1'b1;
    sif.flush     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sym_data[i] = 8'($urandom);
      m_sym[i]    = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_symbol();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
